// File: rtl/ni_packetizer.sv
// Network-interface transmit side: buffers whole messages in a small FIFO and serializes
// each into head/body/tail flits for the router local port under credit flow control.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

module ni_packetizer #(
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int DATA_W     = 32,
    parameter int BODY_FLITS = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_val,
    output logic                              o_rdy,
    input  logic [$clog2(`X_NODES)-1:0]       i_x_dest,
    input  logic [$clog2(`Y_NODES)-1:0]       i_y_dest,
    input  logic [BODY_FLITS*DATA_W-1:0]      i_data,
    output logic                              o_flit_val,
    output logic                              o_flit_head,
    output logic                              o_flit_tail,
    output logic [DATA_W-1:0]                 o_flit_data,
    output logic [$clog2(`X_NODES)-1:0]       o_x_dest,
    output logic [$clog2(`Y_NODES)-1:0]       o_y_dest,
    input  logic                              i_credit,
    output logic                              o_credit_err
);

    localparam int XW = $clog2(`X_NODES);
    localparam int YW = $clog2(`Y_NODES);
    localparam int PW = BODY_FLITS * DATA_W;
    localparam int EW = XW + YW + PW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int BW = (BODY_FLITS > 1) ? $clog2(BODY_FLITS) : 1;

    // Head flit carries the source coordinates so the receiver knows who sent it.
    localparam logic [DATA_W-1:0] SRC_FLIT = DATA_W'({XW'(X_LOC), YW'(Y_LOC)});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic [BW-1:0]       r_beat;
    logic [CW-1:0]       r_credits;
    logic                r_credit_err;

    logic                w_push;
    logic                w_pop;
    logic                w_send;
    logic                w_last_beat;
    logic [EW-1:0]       w_ent;
    logic [XW-1:0]       w_ent_x;
    logic [YW-1:0]       w_ent_y;
    logic [PW-1:0]       w_payload;
    logic [DATA_W-1:0]   w_body [BODY_FLITS];

    assign o_rdy       = (r_count != (AW+1)'(FIFO_DEPTH));
    assign w_push      = i_val && o_rdy;
    assign w_send      = (r_state != S_IDLE) && (r_credits != '0);
    assign w_last_beat = (r_beat == BW'(BODY_FLITS - 1));
    assign w_pop       = w_send && (r_state == S_BODY) && w_last_beat;
    assign o_flit_val  = w_send;
    assign o_credit_err = r_credit_err;

    assign w_ent     = r_mem[r_rd_ptr];
    assign w_ent_x   = w_ent[EW-1 -: XW];
    assign w_ent_y   = w_ent[PW +: YW];
    assign w_payload = w_ent[PW-1:0];

    generate
        for (genvar gi = 0; gi < BODY_FLITS; gi++) begin : g_body
            assign w_body[gi] = w_payload[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Message storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_x_dest, i_y_dest, i_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Follow-on packet starts straight from the tail only if it was already queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_next = S_HEAD;
            S_HEAD: if (w_send) w_state_next = S_BODY;
            S_BODY: if (w_pop) w_state_next = (r_count > (AW+1)'(1)) ? S_HEAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_flit_head = 1'b0;
        o_flit_tail = 1'b0;
        o_flit_data = '0;
        o_x_dest    = '0;
        o_y_dest    = '0;
        case (r_state)
            S_HEAD: begin
                o_flit_head = 1'b1;
                o_flit_data = SRC_FLIT;
                o_x_dest    = w_ent_x;
                o_y_dest    = w_ent_y;
            end
            S_BODY: begin
                o_flit_tail = w_last_beat;
                o_flit_data = w_body[r_beat];
                o_x_dest    = w_ent_x;
                o_y_dest    = w_ent_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
        end else if (w_send) begin
            if (r_state == S_HEAD || w_last_beat) r_beat <= '0;
            else                                  r_beat <= r_beat + 1'b1;
        end
    end

    // A send and a returned credit in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits    <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            if (w_send && !i_credit) begin
                r_credits <= r_credits - 1'b1;
            end else if (i_credit && !w_send) begin
                if (r_credits == CW'(CREDITS)) r_credit_err <= 1'b1;
                else                           r_credits    <= r_credits + 1'b1;
            end
        end
    end

endmodule
